// File: rtl/data_ram_pkg.sv
// Shared constants, address map and decode helper for the unified data memory.
// Every file in the data_ram slice imports this package.
package data_ram_pkg;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 16;
    localparam int RAM_DEPTH = 512;

    localparam logic [ADDR_W-1:0] ADDR_WREG  = 11'h200;
    localparam logic [ADDR_W-1:0] ADDR_CARRY = 11'h201;
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = 11'h202;
    localparam logic [ADDR_W-1:0] ADDR_INDF  = 11'h203;
    localparam logic [ADDR_W-1:0] ADDR_FSR   = 11'h204;

    localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(RAM_DEPTH);

    typedef enum logic [2:0] {
        REG_RAM,
        REG_WREG,
        REG_CARRY,
        REG_ZERO,
        REG_INDF,
        REG_FSR,
        REG_NONE
    } region_e;

    function automatic region_e decode_addr(input logic [ADDR_W-1:0] a);
        region_e r;
        r = REG_NONE;
        if (a < RAM_TOP) begin
            r = REG_RAM;
        end else begin
            case (a)
                ADDR_WREG:  r = REG_WREG;
                ADDR_CARRY: r = REG_CARRY;
                ADDR_ZERO:  r = REG_ZERO;
                ADDR_INDF:  r = REG_INDF;
                ADDR_FSR:   r = REG_FSR;
                default:    r = REG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/data_ram_flag_reg.sv
// One-bit status flag: loads the ALU result every clock unless a register
// write to this flag overrides it in the same cycle.
module flag_reg
    import data_ram_pkg::*;
(
    input  logic clk,
    input  logic reset_bar,
    input  logic load_val,
    input  logic wr_en,
    input  logic wr_val,
    output logic q
);

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            q <= 1'b0;
        end else if (wr_en) begin
            q <= wr_val;
        end else begin
            q <= load_val;
        end
    end

endmodule

// File: rtl/data_ram.sv
// Unified data memory: 512-word RAM plus memory-mapped W readback, carry,
// zero, indirect data (INDF) and indirect pointer (FSR) registers.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_W    = data_ram_pkg::ADDR_W,
    parameter int DATA_W    = data_ram_pkg::DATA_W,
    parameter int RAM_DEPTH = data_ram_pkg::RAM_DEPTH
)(
    input  logic              clk,
    input  logic              reset_bar,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              write_enable,
    output logic [DATA_W-1:0] out_data,
    input  logic [DATA_W-1:0] wreg,
    input  logic              carry_in,
    input  logic              zero_in,
    output logic              carry_out,
    output logic              zero_out
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    logic [DATA_W-1:0] mem [RAM_DEPTH];
    logic [DATA_W-1:0] fsr;
    logic [RAM_AW-1:0] fsr_ptr;
    logic [RAM_AW-1:0] ram_waddr;
    logic              ram_we;
    logic              fsr_we;
    logic              carry_wr;
    logic              zero_wr;
    region_e           region;

    assign region  = decode_addr(addr);
    assign fsr_ptr = fsr[RAM_AW-1:0];

    // INDF resolves through fsr[8:0] only, so it can never alias a special register
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = addr[RAM_AW-1:0];
        fsr_we    = 1'b0;
        carry_wr  = 1'b0;
        zero_wr   = 1'b0;
        if (write_enable) begin
            case (region)
                REG_RAM:   ram_we = 1'b1;
                REG_INDF: begin
                    ram_we    = 1'b1;
                    ram_waddr = fsr_ptr;
                end
                REG_FSR:   fsr_we   = 1'b1;
                REG_CARRY: carry_wr = 1'b1;
                REG_ZERO:  zero_wr  = 1'b1;
                default:   ram_we   = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            fsr <= '0;
        end else if (fsr_we) begin
            fsr <= in_data;
        end
    end

    flag_reg u_carry (
        .clk       (clk),
        .reset_bar (reset_bar),
        .load_val  (carry_in),
        .wr_en     (carry_wr),
        .wr_val    (in_data[0]),
        .q         (carry_out)
    );

    flag_reg u_zero (
        .clk       (clk),
        .reset_bar (reset_bar),
        .load_val  (zero_in),
        .wr_en     (zero_wr),
        .wr_val    (in_data[0]),
        .q         (zero_out)
    );

    always_comb begin
        out_data = '0;
        case (region)
            REG_RAM:   out_data = mem[addr[RAM_AW-1:0]];
            REG_WREG:  out_data = wreg;
            REG_CARRY: out_data = {{(DATA_W-1){1'b0}}, carry_out};
            REG_ZERO:  out_data = {{(DATA_W-1){1'b0}}, zero_out};
            REG_INDF:  out_data = mem[fsr_ptr];
            REG_FSR:   out_data = fsr;
            default:   out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: directed vector table, async reset sequence and
// randomized traffic against an address-map level reference model.
module tb_data_ram;

    logic        clk;
    logic        reset_bar;
    logic [10:0] addr;
    logic [15:0] in_data;
    logic        write_enable;
    logic [15:0] out_data;
    logic [15:0] wreg;
    logic        carry_in;
    logic        zero_in;
    logic        carry_out;
    logic        zero_out;

    int checks = 0;
    int errors = 0;

    data_ram dut (
        .clk          (clk),
        .reset_bar    (reset_bar),
        .addr         (addr),
        .in_data      (in_data),
        .write_enable (write_enable),
        .out_data     (out_data),
        .wreg         (wreg),
        .carry_in     (carry_in),
        .zero_in      (zero_in),
        .carry_out    (carry_out),
        .zero_out     (zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [10:0] a;
        logic [15:0] d;
        logic        ci;
        logic        zi;
        logic [15:0] w;
        logic [15:0] exp_out;
        logic        exp_c;
        logic        exp_z;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    logic [15:0] m_mem [512];
    logic [15:0] m_fsr;
    logic        m_carry;
    logic        m_zero;

    function automatic void add(input logic we, input logic [10:0] a, input logic [15:0] d,
                                input logic ci, input logic zi, input logic [15:0] w,
                                input logic [15:0] eo, input logic ec, input logic ez);
        vec_t v;
        v.we = we; v.a = a; v.d = d; v.ci = ci; v.zi = zi; v.w = w;
        v.exp_out = eo; v.exp_c = ec; v.exp_z = ez;
        tbl.push_back(v);
    endfunction

    function automatic logic [15:0] model_read(input logic [10:0] a, input logic [15:0] w);
        if (a < 11'd512) return m_mem[a[8:0]];
        if (a == 11'h200) return w;
        if (a == 11'h201) return {15'd0, m_carry};
        if (a == 11'h202) return {15'd0, m_zero};
        if (a == 11'h203) return m_mem[m_fsr[8:0]];
        if (a == 11'h204) return m_fsr;
        return 16'h0000;
    endfunction

    function automatic void model_clock(input vec_t v);
        if (v.we) begin
            if (v.a < 11'd512) m_mem[v.a[8:0]] = v.d;
            else if (v.a == 11'h203) m_mem[m_fsr[8:0]] = v.d;
            else if (v.a == 11'h204) m_fsr = v.d;
        end
        m_carry = (v.we && v.a == 11'h201) ? v.d[0] : v.ci;
        m_zero  = (v.we && v.a == 11'h202) ? v.d[0] : v.zi;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // mode 0: no check, 1: table expectations, 2: model expectations
    task automatic step(input vec_t v, input int mode, input string tag);
        write_enable = v.we;
        addr         = v.a;
        in_data      = v.d;
        carry_in     = v.ci;
        zero_in      = v.zi;
        wreg         = v.w;
        @(negedge clk);
        if (mode == 1) begin
            check16({tag, " out"}, out_data, v.exp_out);
            check1({tag, " carry"}, carry_out, v.exp_c);
            check1({tag, " zero"}, zero_out, v.exp_z);
        end else if (mode == 2) begin
            check16({tag, " out"}, out_data, model_read(v.a, v.w));
            check1({tag, " carry"}, carry_out, m_carry);
            check1({tag, " zero"}, zero_out, m_zero);
        end
        @(posedge clk);
        model_clock(v);
        #1;
    endtask

    initial begin
        vec_t v;
        reset_bar    = 1'b1;
        addr         = 11'h204;
        in_data      = '0;
        write_enable = 1'b0;
        wreg         = '0;
        carry_in     = 1'b0;
        zero_in      = 1'b0;
        m_fsr = '0; m_carry = 1'b0; m_zero = 1'b0;

        #2 reset_bar = 1'b0;
        #10;
        check1("rst carry", carry_out, 1'b0);
        check1("rst zero", zero_out, 1'b0);
        check16("rst fsr", out_data, 16'h0000);
        #11 reset_bar = 1'b1;
        @(posedge clk);
        #1;

        // clear RAM so the directed table starts from known contents
        for (int i = 0; i < 512; i++) begin
            v = '{1'b1, 11'(i), 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0};
            step(v, 0, "init");
        end

        //   we  addr     din      ci  zi  wreg     exp_out  c   z
        add(1, 11'h000, 16'hDEAD, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 11'h000, 16'h0000, 0, 0, 16'h0000, 16'hDEAD, 0, 0);
        add(1, 11'h001, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 11'h001, 16'h0000, 0, 0, 16'h0000, 16'hBEEF, 0, 0);
        add(1, 11'h204, 16'h0001, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 11'h203, 16'h0000, 0, 0, 16'h0000, 16'hBEEF, 0, 0);
        add(0, 11'h204, 16'h0000, 0, 0, 16'h0000, 16'h0001, 0, 0);
        add(1, 11'h203, 16'h1234, 0, 0, 16'h0000, 16'hBEEF, 0, 0);
        add(0, 11'h001, 16'h0000, 0, 0, 16'h0000, 16'h1234, 0, 0);
        add(0, 11'h200, 16'h0000, 0, 0, 16'hC0DE, 16'hC0DE, 0, 0);
        add(1, 11'h200, 16'h5555, 0, 0, 16'hC0DE, 16'hC0DE, 0, 0);
        add(0, 11'h204, 16'h0000, 0, 0, 16'hC0DE, 16'h0001, 0, 0);
        add(0, 11'h000, 16'h0000, 0, 0, 16'hC0DE, 16'hDEAD, 0, 0);
        add(0, 11'h201, 16'h0000, 1, 1, 16'h0000, 16'h0000, 0, 0);
        add(0, 11'h201, 16'h0000, 1, 1, 16'h0000, 16'h0001, 1, 1);
        add(0, 11'h202, 16'h0000, 1, 1, 16'h0000, 16'h0001, 1, 1);
        add(1, 11'h201, 16'h0000, 1, 1, 16'h0000, 16'h0001, 1, 1);
        add(0, 11'h201, 16'h0000, 1, 1, 16'h0000, 16'h0000, 0, 1);
        add(1, 11'h202, 16'h0000, 1, 1, 16'h0000, 16'h0001, 1, 1);
        add(0, 11'h202, 16'h0000, 1, 1, 16'h0000, 16'h0000, 1, 0);
        add(0, 11'h202, 16'h0000, 1, 1, 16'h0000, 16'h0001, 1, 1);
        add(0, 11'h7FF, 16'h0000, 1, 1, 16'h0000, 16'h0000, 1, 1);
        add(1, 11'h205, 16'hFFFF, 1, 1, 16'h0000, 16'h0000, 1, 1);
        add(1, 11'h201, 16'hFFFE, 1, 0, 16'h0000, 16'h0001, 1, 1);
        add(0, 11'h201, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(1, 11'h204, 16'hFE05, 0, 0, 16'h0000, 16'h0001, 0, 0);
        add(1, 11'h203, 16'h7777, 0, 0, 16'h0000, 16'h0000, 0, 0);
        add(0, 11'h005, 16'h0000, 0, 0, 16'h0000, 16'h7777, 0, 0);
        add(0, 11'h204, 16'h0000, 0, 0, 16'h0000, 16'hFE05, 0, 0);
        add(0, 11'h205, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0);

        foreach (tbl[i]) step(tbl[i], 1, $sformatf("tbl%0d", i));

        // mid-cycle asynchronous reset with flags and fsr set
        v = '{1'b1, 11'h204, 16'h0001, 1'b1, 1'b1, 16'h0000, 16'h0, 1'b0, 1'b0};
        write_enable = v.we; addr = v.a; in_data = v.d; carry_in = 1'b1; zero_in = 1'b1;
        @(posedge clk);
        model_clock(v);
        #1;
        write_enable = 1'b0;
        #1;
        check1("pre-rst carry", carry_out, 1'b1);
        check1("pre-rst zero", zero_out, 1'b1);
        check16("pre-rst fsr", out_data, 16'h0001);
        #1 reset_bar = 1'b0;
        #1;
        check1("async carry", carry_out, 1'b0);
        check1("async zero", zero_out, 1'b0);
        check16("async fsr", out_data, 16'h0000);
        addr = 11'h7FF;
        #1;
        check16("unmapped 7FF", out_data, 16'h0000);
        @(posedge clk);
        #1;
        check1("rst held carry", carry_out, 1'b0);
        reset_bar = 1'b1;
        m_carry = 1'b0; m_zero = 1'b0; m_fsr = '0;
        v = '{1'b0, 11'h001, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0};
        step(v, 2, "ram kept");

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            v.we = 1'($urandom_range(0, 1));
            if (sel < 5)       v.a = 11'($urandom_range(0, 511));
            else if (sel < 8)  v.a = 11'h200 + 11'($urandom_range(0, 5));
            else if (sel == 8) v.a = 11'($urandom);
            else               v.a = 11'h203;
            v.d  = 16'($urandom);
            v.ci = 1'($urandom_range(0, 1));
            v.zi = 1'($urandom_range(0, 1));
            v.w  = 16'($urandom);
            step(v, 2, $sformatf("rnd%0d a=%h", n, v.a));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
